branch_resolve: RTL and testbench
=================================

# branch_resolve

Execute-stage branch resolution unit: the producer side of the predictor's `ex*` feedback interface. Compares the prediction carried down the pipeline with the actual outcome, drives registered training feedback (`exVld`..`exKnown`) to the predictor, and issues a one-cycle fetch redirect on misprediction. An epoch bit discards wrong-path instructions until the redirected stream arrives. Saturating branch and mispredict counters are kept for performance analysis.

## Interface
- `ADDR_WIDTH`, 32, PC and target width.
- `CNT_WIDTH`, 32, width of each performance counter.

- `clk` in 1: the block's single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `inVld` in 1: instruction present in EX this cycle.
- `inStall` in 1: EX stalled; input is held and not consumed.
- `inPC` in ADDR_WIDTH: PC of the EX instruction.
- `inType` in 2: 00 non-branch, 01 conditional direct, 10 unconditional direct, 11 indirect.
- `inCond` in 1: condition result from the ALU. Used only for type 01.
- `inTarget` in ADDR_WIDTH: computed branch target. `inTarget[1:0]` is ignored and treated as 00.
- `inPdBranch` in 1: predictor said taken.
- `inPdPC` in ADDR_WIDTH: predicted next PC.
- `inPdKnown` in 1: prediction came from a known history entry.
- `inEpoch` in 1: epoch tag attached at fetch.
- `cntClr` in 1: synchronous counter clear.
- `exVld`, `exPC`, `exPCTar`, `exType`, `exBranch`, `exWrong`, `exKnown` out 1/AW/AW/2/1/1/1: registered predictor feedback.
- `redirVld` out 1: one-cycle fetch redirect.
- `redirPC` out ADDR_WIDTH: redirect target.
- `epoch` out 1: current epoch, stamped by fetch onto new instructions.
- `brCnt` out CNT_WIDTH: resolved branches.
- `missCnt` out CNT_WIDTH: mispredicts.

## Operation
- An instruction is accepted when `inVld & ~inStall & (inEpoch == epoch)`.
  - An epoch-mismatched instruction is dropped silently: no feedback, no redirect, no counter update.
- Actual taken:
  - type 00: 0
  - type 01: `inCond`
  - types 10 and 11: 1
- Actual next PC = taken ? {inTarget[AW-1:2],2'b00} : inPC+4. The addition wraps modulo 2^ADDR_WIDTH.
- Wrong = (inPdBranch != taken) | (taken & inPdPC != actual next PC). Type 00 with `inPdBranch`=1 counts as wrong.
- Feedback is generated when accepted & (type != 00 | wrong). The registered outputs are:
  - `exVld`=1
  - `exPC`=inPC
  - `exPCTar`=actual next PC
  - `exType`=inType
  - `exBranch`=taken
  - `exWrong`=wrong
  - `exKnown`=inPdKnown
- On accepted & wrong:
  - `redirVld`=1 and `redirPC`=actual next PC.
  - `epoch` toggles.
- Counters, on accepted instructions only:
  - `brCnt` increments for type != 00.
  - `missCnt` increments on wrong.
  - Both saturate at all-ones.
  - `cntClr` has priority over increment.
- Stall: outputs fall to 0 (`exVld`, `redirVld`). The data fields hold their previous values, and `epoch` holds.

## Timing
- Latency is 1 cycle: input at edge N produces outputs valid after edge N+1. Nothing is combinational from input to output.
- `exVld` and `redirVld` are single-cycle pulses per accepted instruction. There is no handshake: the predictor and fetch must sample every cycle.
- `epoch` updates at the same edge as `redirVld`. An instruction presented in cycle N+1 still carrying the old epoch is dropped.
- Back-to-back mispredicts in consecutive cycles are impossible without an epoch change. The second one is dropped by the epoch check.
- Reset (asynchronous, any cycle) clears to 0 all of:
  - `exVld`, `exPC`, `exPCTar`, `exType`, `exBranch`, `exWrong`, `exKnown`
  - `redirVld`, `redirPC`
  - `epoch`, `brCnt`, `missCnt`
- An in-flight redirect is lost on reset; fetch restarts from its own reset vector.
- `cntClr` and an increment in the same cycle: the counter becomes 0.

## Test plan
- **Correct taken conditional.** Inputs: PC=0x1000, type 01, cond=1, target=0x0F00, pdBranch=1, pdPC=0x0F00, epoch match. Expected next cycle: exVld=1, exBranch=1, exWrong=0, exPCTar=0x0F00, redirVld=0, brCnt=1, missCnt=0.
- **Direction mispredict.** Inputs: PC=0x2000, type 01, cond=0, pdBranch=1, pdPC=0x2400. Expected: exWrong=1, redirVld=1, redirPC=0x2004, epoch 0→1, missCnt=1. A following instruction with inEpoch=0 produces no exVld.
- **Indirect target mispredict.** Inputs: type 11, target=0x3002, pdBranch=1, pdPC=0x3100. Expected: redirPC=0x3000, exPCTar=0x3000, exWrong=1.
- **False prediction on non-branch.** Inputs: type 00, PC=0x4000, pdBranch=1. Expected: exVld=1, exType=00, exBranch=0, redirPC=0x4004, brCnt unchanged, missCnt+1. Type 00 with pdBranch=0 produces no output pulse.
- **Wrap and saturation.** Inputs: PC=0xFFFFFFFC, type 01, cond=0, pdBranch=1. Expected: redirPC=0x00000000. Separately, preload missCnt=0xFFFFFFFF, apply a mispredict, and expect it to stay 0xFFFFFFFF; assert cntClr and expect 0.
- **Stall and reset.** Hold inStall=1 with a valid mispredicting input for 3 cycles: expect no pulses and epoch unchanged; release and expect exactly one redirect. Assert rst mid-pulse: exVld, redirVld, epoch and counters go to 0 immediately, without a clock edge.

Source files
------------

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: compares the carried prediction with the real
// outcome, emits registered predictor feedback, fetch redirects and perf counters.
module branch_resolve #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inVld,
  input  logic                  inStall,
  input  logic [ADDR_WIDTH-1:0] inPC,
  input  logic [1:0]            inType,
  input  logic                  inCond,
  input  logic [ADDR_WIDTH-1:0] inTarget,
  input  logic                  inPdBranch,
  input  logic [ADDR_WIDTH-1:0] inPdPC,
  input  logic                  inPdKnown,
  input  logic                  inEpoch,
  input  logic                  cntClr,
  output logic                  exVld,
  output logic [ADDR_WIDTH-1:0] exPC,
  output logic [ADDR_WIDTH-1:0] exPCTar,
  output logic [1:0]            exType,
  output logic                  exBranch,
  output logic                  exWrong,
  output logic                  exKnown,
  output logic                  redirVld,
  output logic [ADDR_WIDTH-1:0] redirPC,
  output logic                  epoch,
  output logic [CNT_WIDTH-1:0]  brCnt,
  output logic [CNT_WIDTH-1:0]  missCnt
);

  logic                  r_exVld;
  logic [ADDR_WIDTH-1:0] r_exPC;
  logic [ADDR_WIDTH-1:0] r_exPCTar;
  logic [1:0]            r_exType;
  logic                  r_exBranch;
  logic                  r_exWrong;
  logic                  r_exKnown;
  logic                  r_redirVld;
  logic [ADDR_WIDTH-1:0] r_redirPC;
  logic                  r_epoch;
  logic [CNT_WIDTH-1:0]  r_brCnt;
  logic [CNT_WIDTH-1:0]  r_missCnt;

  logic                  w_accept;
  logic                  w_taken;
  logic                  w_wrong;
  logic                  w_fb;
  logic                  w_isBranch;
  logic [ADDR_WIDTH-1:0] w_nextPC;

  always_comb begin
    w_accept   = inVld & ~inStall & (inEpoch == r_epoch);
    w_isBranch = (inType != 2'b00);
    case (inType)
      2'b00:   w_taken = 1'b0;
      2'b01:   w_taken = inCond;
      default: w_taken = 1'b1;
    endcase
    w_nextPC = w_taken ? {inTarget[ADDR_WIDTH-1:2], 2'b00} : (inPC + ADDR_WIDTH'(4));
    w_wrong  = (inPdBranch != w_taken) | (w_taken & (inPdPC != w_nextPC));
    w_fb     = w_accept & (w_isBranch | w_wrong);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exVld    <= 1'b0;
      r_exPC     <= '0;
      r_exPCTar  <= '0;
      r_exType   <= '0;
      r_exBranch <= 1'b0;
      r_exWrong  <= 1'b0;
      r_exKnown  <= 1'b0;
      r_redirVld <= 1'b0;
      r_redirPC  <= '0;
      r_epoch    <= 1'b0;
      r_brCnt    <= '0;
      r_missCnt  <= '0;
    end else begin
      // Pulses drop whenever nothing is accepted; payload fields keep their last value.
      r_exVld    <= w_fb;
      r_redirVld <= w_accept & w_wrong;
      if (w_fb) begin
        r_exPC     <= inPC;
        r_exPCTar  <= w_nextPC;
        r_exType   <= inType;
        r_exBranch <= w_taken;
        r_exWrong  <= w_wrong;
        r_exKnown  <= inPdKnown;
      end
      if (w_accept & w_wrong) begin
        r_redirPC <= w_nextPC;
        r_epoch   <= ~r_epoch;
      end
      if (cntClr) begin
        r_brCnt   <= '0;
        r_missCnt <= '0;
      end else if (w_accept) begin
        if (w_isBranch && (r_brCnt != '1)) r_brCnt <= r_brCnt + 1'b1;
        if (w_wrong && (r_missCnt != '1)) r_missCnt <= r_missCnt + 1'b1;
      end
    end
  end

  assign exVld    = r_exVld;
  assign exPC     = r_exPC;
  assign exPCTar  = r_exPCTar;
  assign exType   = r_exType;
  assign exBranch = r_exBranch;
  assign exWrong  = r_exWrong;
  assign exKnown  = r_exKnown;
  assign redirVld = r_redirVld;
  assign redirPC  = r_redirPC;
  assign epoch    = r_epoch;
  assign brCnt    = r_brCnt;
  assign missCnt  = r_missCnt;

endmodule

// File: tb/tb_branch_resolve.sv
// Randomized and directed bench for branch_resolve against a behavioural model;
// a narrow-counter instance shares the stimulus to reach counter saturation.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        inVld, inStall, inCond, inPdBranch, inPdKnown, inEpoch, cntClr;
  logic [31:0] inPC, inTarget, inPdPC;
  logic [1:0]  inType;

  logic        exVld, exBranch, exWrong, exKnown, redirVld, epoch;
  logic [31:0] exPC, exPCTar, redirPC, brCnt, missCnt;
  logic [1:0]  exType;

  logic        s_exVld, s_exBranch, s_exWrong, s_exKnown, s_redirVld, s_epoch;
  logic [31:0] s_exPC, s_exPCTar, s_redirPC;
  logic [1:0]  s_exType;
  logic [3:0]  s_brCnt, s_missCnt;

  int total = 0;
  int bad   = 0;

  // model state
  bit        m_exVld, m_exBranch, m_exWrong, m_exKnown, m_redirVld, m_epoch;
  bit [31:0] m_exPC, m_exPCTar, m_redirPC;
  bit [1:0]  m_exType;
  longint    m_br, m_miss, ms_br, ms_miss;

  always #5 clk = ~clk;

  branch_resolve dut (
    .clk(clk), .rst(rst), .inVld(inVld), .inStall(inStall), .inPC(inPC), .inType(inType),
    .inCond(inCond), .inTarget(inTarget), .inPdBranch(inPdBranch), .inPdPC(inPdPC),
    .inPdKnown(inPdKnown), .inEpoch(inEpoch), .cntClr(cntClr),
    .exVld(exVld), .exPC(exPC), .exPCTar(exPCTar), .exType(exType), .exBranch(exBranch),
    .exWrong(exWrong), .exKnown(exKnown), .redirVld(redirVld), .redirPC(redirPC),
    .epoch(epoch), .brCnt(brCnt), .missCnt(missCnt)
  );

  branch_resolve #(.ADDR_WIDTH(32), .CNT_WIDTH(4)) dut_small (
    .clk(clk), .rst(rst), .inVld(inVld), .inStall(inStall), .inPC(inPC), .inType(inType),
    .inCond(inCond), .inTarget(inTarget), .inPdBranch(inPdBranch), .inPdPC(inPdPC),
    .inPdKnown(inPdKnown), .inEpoch(inEpoch), .cntClr(cntClr),
    .exVld(s_exVld), .exPC(s_exPC), .exPCTar(s_exPCTar), .exType(s_exType),
    .exBranch(s_exBranch), .exWrong(s_exWrong), .exKnown(s_exKnown),
    .redirVld(s_redirVld), .redirPC(s_redirPC), .epoch(s_epoch),
    .brCnt(s_brCnt), .missCnt(s_missCnt)
  );

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_exVld = 0; m_exBranch = 0; m_exWrong = 0; m_exKnown = 0; m_redirVld = 0; m_epoch = 0;
    m_exPC = 0; m_exPCTar = 0; m_redirPC = 0; m_exType = 0;
    m_br = 0; m_miss = 0; ms_br = 0; ms_miss = 0;
  endtask

  // One clock edge of the architectural rules applied to the current inputs.
  task automatic model_edge();
    bit acc, taken, wrong;
    bit [31:0] nxt;
    if (rst) begin
      model_reset();
      return;
    end
    acc   = inVld && !inStall && (inEpoch == m_epoch);
    taken = (inType == 2'd0) ? 1'b0 : (inType == 2'd1) ? inCond : 1'b1;
    nxt   = taken ? (inTarget & 32'hFFFF_FFFC) : inPC + 32'd4;
    wrong = taken ? (!inPdBranch || inPdPC != nxt) : inPdBranch;
    m_exVld    = acc && (inType != 0 || wrong);
    m_redirVld = acc && wrong;
    if (m_exVld) begin
      m_exPC = inPC; m_exPCTar = nxt; m_exType = inType;
      m_exBranch = taken; m_exWrong = wrong; m_exKnown = inPdKnown;
    end
    if (m_redirVld) begin
      m_redirPC = nxt;
      m_epoch   = !m_epoch;
    end
    if (cntClr) begin
      m_br = 0; m_miss = 0; ms_br = 0; ms_miss = 0;
    end else if (acc) begin
      if (inType != 0) begin
        if (m_br < 64'hFFFF_FFFF) m_br++;
        if (ms_br < 15) ms_br++;
      end
      if (wrong) begin
        if (m_miss < 64'hFFFF_FFFF) m_miss++;
        if (ms_miss < 15) ms_miss++;
      end
    end
  endtask

  task automatic compare_all();
    check("exVld", exVld, m_exVld);
    check("redirVld", redirVld, m_redirVld);
    check("epoch", epoch, m_epoch);
    check("exPC", exPC, m_exPC);
    check("exPCTar", exPCTar, m_exPCTar);
    check("exType", exType, m_exType);
    check("exBranch", exBranch, m_exBranch);
    check("exWrong", exWrong, m_exWrong);
    check("exKnown", exKnown, m_exKnown);
    check("redirPC", redirPC, m_redirPC);
    check("brCnt", brCnt, m_br);
    check("missCnt", missCnt, m_miss);
    check("small_brCnt", s_brCnt, ms_br);
    check("small_missCnt", s_missCnt, ms_miss);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input bit vld, input bit stall, input bit [31:0] pc, input bit [1:0] typ,
                       input bit cond, input bit [31:0] tgt, input bit pdb, input bit [31:0] pdpc,
                       input bit known, input bit ep);
    inVld = vld; inStall = stall; inPC = pc; inType = typ; inCond = cond; inTarget = tgt;
    inPdBranch = pdb; inPdPC = pdpc; inPdKnown = known; inEpoch = ep;
  endtask

  initial begin
    rst = 1'b1;
    cntClr = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check("reset_exVld", exVld, 0);
    check("reset_epoch", epoch, 0);
    check("reset_missCnt", missCnt, 0);
    compare_all();
    rst = 1'b0;

    // correct taken conditional
    drive(1, 0, 32'h1000, 2'b01, 1, 32'h0F00, 1, 32'h0F00, 1, 0);
    step();
    check("t1_exVld", exVld, 1);
    check("t1_exBranch", exBranch, 1);
    check("t1_exWrong", exWrong, 0);
    check("t1_exPCTar", exPCTar, 32'h0F00);
    check("t1_redirVld", redirVld, 0);
    check("t1_brCnt", brCnt, 1);
    check("t1_missCnt", missCnt, 0);

    // direction mispredict, then stale-epoch instruction dropped
    drive(1, 0, 32'h2000, 2'b01, 0, 32'h2400, 1, 32'h2400, 0, 0);
    step();
    check("t2_exWrong", exWrong, 1);
    check("t2_redirVld", redirVld, 1);
    check("t2_redirPC", redirPC, 32'h2004);
    check("t2_epoch", epoch, 1);
    check("t2_missCnt", missCnt, 1);
    drive(1, 0, 32'h2400, 2'b01, 1, 32'h2800, 1, 32'h2800, 0, 0);
    step();
    check("t2_stale_exVld", exVld, 0);
    check("t2_stale_brCnt", brCnt, 2);

    // indirect target mispredict (target low bits ignored)
    drive(1, 0, 32'h2004, 2'b11, 0, 32'h3002, 1, 32'h3100, 1, 1);
    step();
    check("t3_redirPC", redirPC, 32'h3000);
    check("t3_exPCTar", exPCTar, 32'h3000);
    check("t3_exWrong", exWrong, 1);

    // false prediction on a non-branch, then quiet non-branch
    drive(1, 0, 32'h4000, 2'b00, 0, 32'h0, 1, 32'h5000, 0, 0);
    step();
    check("t4_exVld", exVld, 1);
    check("t4_exType", exType, 0);
    check("t4_exBranch", exBranch, 0);
    check("t4_redirPC", redirPC, 32'h4004);
    check("t4_brCnt", brCnt, 3);
    check("t4_missCnt", missCnt, 3);
    drive(1, 0, 32'h4004, 2'b00, 0, 32'h0, 0, 32'h0, 0, 1);
    step();
    check("t4_quiet_exVld", exVld, 0);
    check("t4_quiet_redirVld", redirVld, 0);

    // PC+4 wraps
    drive(1, 0, 32'hFFFF_FFFC, 2'b01, 0, 32'h100, 1, 32'h100, 0, 1);
    step();
    check("t5_redirPC_wrap", redirPC, 32'h0);

    // stall with a pending mispredict
    drive(1, 1, 32'h6000, 2'b01, 0, 32'h6100, 1, 32'h6100, 0, m_epoch);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_exVld", exVld, 0);
      check("stall_redirVld", redirVld, 0);
      check("stall_epoch", epoch, 0);
    end
    inStall = 0;
    step();
    check("unstall_redirVld", redirVld, 1);
    inVld = 0;
    step();
    check("unstall_single", redirVld, 0);

    // saturation of narrow counters; clear wins over increment
    cntClr = 1;
    step();
    cntClr = 0;
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 32'h7000 + 32'(i * 16), 2'b01, 0, 32'h9000, 1, 32'h9000, 0, m_epoch);
      step();
    end
    check("sat_small_missCnt", s_missCnt, 4'hF);
    check("sat_missCnt", missCnt, 17);
    drive(1, 0, 32'h8000, 2'b01, 0, 32'h9000, 1, 32'h9000, 0, m_epoch);
    cntClr = 1;
    step();
    cntClr = 0;
    check("clr_missCnt", missCnt, 0);
    check("clr_small_missCnt", s_missCnt, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit [1:0]  typ  = 2'($urandom_range(3));
      bit        cond = 1'($urandom_range(1));
      bit [31:0] pc   = $urandom & 32'hFFFF_FFFC;
      bit [31:0] tgt  = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom;
      bit        pdb  = 1'($urandom_range(1));
      bit        tk   = (typ == 0) ? 1'b0 : (typ == 1) ? cond : 1'b1;
      bit [31:0] good = tk ? {tgt[31:2], 2'b00} : pc + 32'd4;
      bit [31:0] pdpc = ($urandom_range(1) == 0) ? good : $urandom;
      bit        ep   = ($urandom_range(9) == 0) ? !m_epoch : m_epoch;
      drive(($urandom_range(4) != 0), ($urandom_range(4) == 0), pc, typ, cond, tgt,
            pdb, pdpc, 1'($urandom_range(1)), ep);
      cntClr = ($urandom_range(199) == 0);
      step();
    end
    cntClr = 0;

    // asynchronous reset in the middle of a pulse
    drive(1, 0, 32'hA000, 2'b10, 0, 32'hB000, 1, 32'hC000, 1, m_epoch);
    step();
    check("prerst_exVld", exVld, 1);
    #2;
    rst = 1;
    #1;
    check("arst_exVld", exVld, 0);
    check("arst_redirVld", redirVld, 0);
    check("arst_epoch", epoch, 0);
    check("arst_brCnt", brCnt, 0);
    check("arst_missCnt", missCnt, 0);
    check("arst_redirPC", redirPC, 0);
    model_reset();
    compare_all();
    inVld = 0;
    step();
    rst = 0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
